clk_seq_ctrl: RTL

Power-up and recovery sequencer for the oscilloscope clocking manager that generates the 200 MHz and 400 MHz sampling clocks. It pulses the clocking manager's reset and waits, with a timeout, for a stable lock. It then releases the downstream clock-domain resets one at a time and reports readiness. On lock loss it re-arms the whole sequence. It sits in the `sys_clk` domain, between board reset and the capture/trigger pipelines.

---
 rtl/clk_seq_pkg.sv | 15 +
 rtl/clk_seq_ctrl_sync2.sv | 26 ++
 rtl/clk_seq_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/clk_seq_pkg.sv
// Shared types and constants for the clocking-manager power-up sequencer.
package clk_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/clk_seq_ctrl_sync2.sv
// Generic two-flop synchronizer for slow level signals crossing into the local clock.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/clk_seq_ctrl.sv
// Clocking-manager sequencer: pulses mmcm reset, waits for a settled lock, releases
// downstream domain resets one by one, and re-arms on lock loss or soft restart.
module clk_seq_ctrl
  import clk_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int N_DOM         = 2,
  parameter int STAGE_GAP     = 8
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  mmcm_locked,
  input  logic                  restart,
  output logic                  mmcm_rst,
  output logic [N_DOM-1:0]      dom_rst_n,
  output logic                  clk_ready,
  output logic                  fault,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]            state
);

  localparam int HOLD_W   = $clog2(RST_CYCLES) + 1;
  localparam int LOCK_W   = $clog2(LOCK_TIMEOUT) + 1;
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES) + 1;
  localparam int GAP_W    = $clog2(STAGE_GAP) + 1;
  localparam int RETRY_W  = $clog2(MAX_RETRIES) + 1;
  localparam int K_W      = $clog2(N_DOM) + 1;

  localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RST_CYCLES - 1);
  localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(LOCK_TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(STAGE_GAP - 1);
  localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRIES);
  localparam logic [K_W-1:0]      K_DONE      = K_W'(N_DOM);

  logic                  w_locked_s;

  state_e                r_state,      w_state_next;
  logic [HOLD_W-1:0]     r_hold_cnt,   w_hold_next;
  logic [LOCK_W-1:0]     r_lock_cnt,   w_lock_next;
  logic [SETTLE_W-1:0]   r_settle_cnt, w_settle_next;
  logic [GAP_W-1:0]      r_gap_cnt,    w_gap_next;
  logic [K_W-1:0]        r_k,          w_k_next;
  logic [RETRY_W-1:0]    r_retry,      w_retry_next;
  logic [LOSS_CNT_W-1:0] r_loss_cnt,   w_loss_next;
  logic [N_DOM-1:0]      r_dom,        w_dom_next;
  logic                  r_mmcm_rst;
  logic                  r_clk_ready;
  logic                  r_fault;
  logic                  w_fail;
  logic                  w_advance;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .i_d   (mmcm_locked),
    .o_q   (w_locked_s)
  );

  always_comb begin
    w_state_next  = r_state;
    w_hold_next   = '0;
    w_lock_next   = '0;
    w_settle_next = '0;
    w_gap_next    = '0;
    w_k_next      = r_k;
    w_retry_next  = r_retry;
    w_loss_next   = r_loss_cnt;
    w_dom_next    = r_dom;
    w_fail        = 1'b0;
    w_advance     = 1'b0;

    case (r_state)
      ST_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) w_state_next = ST_WAIT_LOCK;
        else                         w_hold_next  = r_hold_cnt + HOLD_W'(1);
      end
      ST_WAIT_LOCK: begin
        if (w_locked_s)                   w_state_next = ST_SETTLE;
        else if (r_lock_cnt == LOCK_LAST) w_fail       = 1'b1;
        else                              w_lock_next  = r_lock_cnt + LOCK_W'(1);
      end
      ST_SETTLE: begin
        if (!w_locked_s)                      w_fail        = 1'b1;
        else if (r_settle_cnt == SETTLE_LAST) w_state_next  = ST_RELEASE;
        else                                  w_settle_next = r_settle_cnt + SETTLE_W'(1);
      end
      ST_RELEASE: begin
        // A drop here always restarts from HOLD; the retry count saturates at its limit.
        if (!w_locked_s) begin
          w_state_next = ST_HOLD;
          if (r_retry < RETRY_MAX) w_retry_next = r_retry + RETRY_W'(1);
        end else if (r_k == K_DONE) begin
          w_state_next = ST_RUN;
        end else if (r_gap_cnt == GAP_LAST) begin
          w_advance = 1'b1;
          w_k_next  = r_k + K_W'(1);
        end else begin
          w_gap_next = r_gap_cnt + GAP_W'(1);
        end
      end
      ST_RUN: begin
        w_retry_next = '0;
        if (!w_locked_s) begin
          w_state_next = ST_HOLD;
          if (r_loss_cnt != '1) w_loss_next = r_loss_cnt + LOSS_CNT_W'(1);
        end
      end
      ST_FAULT: ;
      default: w_state_next = ST_HOLD;
    endcase

    if (w_fail) begin
      w_retry_next = r_retry + RETRY_W'(1);
      w_state_next = (w_retry_next >= RETRY_MAX) ? ST_FAULT : ST_HOLD;
    end

    // Restart overrides every transition but keeps any lock-loss count taken above.
    if (restart) begin
      w_state_next  = ST_HOLD;
      w_retry_next  = '0;
      w_hold_next   = '0;
      w_lock_next   = '0;
      w_settle_next = '0;
      w_gap_next    = '0;
      w_advance     = 1'b0;
    end

    if (w_state_next != ST_RELEASE) w_k_next = '0;

    if (w_advance) begin
      for (int i = 0; i < N_DOM; i++) begin
        if (r_k == K_W'(i)) w_dom_next[i] = 1'b1;
      end
    end
    if (!(w_state_next inside {ST_RELEASE, ST_RUN})) w_dom_next = '0;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_HOLD;
      r_hold_cnt   <= '0;
      r_lock_cnt   <= '0;
      r_settle_cnt <= '0;
      r_gap_cnt    <= '0;
      r_k          <= '0;
      r_retry      <= '0;
      r_loss_cnt   <= '0;
      r_dom        <= '0;
      r_mmcm_rst   <= 1'b1;
      r_clk_ready  <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_hold_cnt   <= w_hold_next;
      r_lock_cnt   <= w_lock_next;
      r_settle_cnt <= w_settle_next;
      r_gap_cnt    <= w_gap_next;
      r_k          <= w_k_next;
      r_retry      <= w_retry_next;
      r_loss_cnt   <= w_loss_next;
      r_dom        <= w_dom_next;
      r_mmcm_rst   <= (w_state_next == ST_HOLD) || (w_state_next == ST_FAULT);
      r_clk_ready  <= (w_state_next == ST_RUN);
      r_fault      <= (w_state_next == ST_FAULT);
    end
  end

  assign mmcm_rst      = r_mmcm_rst;
  assign dom_rst_n     = r_dom;
  assign clk_ready     = r_clk_ready;
  assign fault         = r_fault;
  assign lock_loss_cnt = r_loss_cnt;
  assign state         = r_state;

endmodule
